cic_interpolator: RTL and testbench

Three-stage CIC interpolator, the transmit-side counterpart of the `CIC` decimator. It accepts one signed 8-bit sample every `interpolation_ratio` clocks, requesting each sample with a one-cycle `d_clk` strobe, and emits one signed 8-bit sample per `clk`. Comb stages run at the low rate, zero-stuffing upsamples, and integrator stages run at the full rate. It sits ahead of the `CIC` decimator in loopback benches and in the DAC-side datapath.

---
 rtl/cic_interpolator.sv | 111 +++++++++++
 tb/tb_cic_interpolator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// rtl/cic_interpolator.sv - three-stage CIC interpolator (M=1)
// Low-rate combs, zero-stuffing upsampler, full-rate pipelined integrators.
module cic_interpolator #(
  parameter int width     = 18,
  parameter int out_shift = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] interpolation_ratio,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_clk
);

  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      r_q, r_d;
  logic [15:0]      r_new;

  logic [width-1:0] x;
  logic [width-1:0] x_z_q, x_z_d;
  logic [width-1:0] c1_q, c1_d, c1_z_q, c1_z_d;
  logic [width-1:0] c2_q, c2_d, c2_z_q, c2_z_d;
  logic [width-1:0] c3_q, c3_d;

  logic             strb_dly_q, strb_dly_d;
  logic [width-1:0] up;
  logic [width-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [7:0]       d_out_q, d_out_d;
  logic             unused_i3;

  // Rate counter: the ratio is only sampled on a strobe so a frame always completes.
  always_comb begin
    d_clk = rst & (cnt_q == 16'd0);
    r_new = (interpolation_ratio > 16'd1) ? interpolation_ratio : 16'd1;
    r_d   = r_q;
    cnt_d = cnt_q;
    if (d_clk) begin
      r_d   = r_new;
      cnt_d = (r_new > 16'd1) ? 16'd1 : 16'd0;
    end else if (cnt_q == r_q - 16'd1) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign x = {{(width-8){d_in[7]}}, d_in};

  always_comb begin
    x_z_d  = x_z_q;
    c1_d   = c1_q;
    c1_z_d = c1_z_q;
    c2_d   = c2_q;
    c2_z_d = c2_z_q;
    c3_d   = c3_q;
    if (d_clk) begin
      c1_d   = x - x_z_q;
      c2_d   = c1_d - c1_z_q;
      c3_d   = c2_d - c2_z_q;
      x_z_d  = x;
      c1_z_d = c1_d;
      c2_z_d = c2_d;
    end
  end

  // The comb result is valid the cycle after the strobe edge, so the stuffer follows strb_dly.
  always_comb begin
    strb_dly_d = d_clk;
    up         = strb_dly_q ? c3_q : '0;
    i1_d       = i1_q + up;
    i2_d       = i2_q + i1_q;
    i3_d       = i3_q + i2_q;
    d_out_d    = i3_q[out_shift+7:out_shift];
  end

  assign unused_i3 = ^i3_q;
  assign d_out     = d_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      r_q        <= '0;
      x_z_q      <= '0;
      c1_q       <= '0;
      c1_z_q     <= '0;
      c2_q       <= '0;
      c2_z_q     <= '0;
      c3_q       <= '0;
      strb_dly_q <= 1'b0;
      i1_q       <= '0;
      i2_q       <= '0;
      i3_q       <= '0;
      d_out_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      x_z_q      <= x_z_d;
      c1_q       <= c1_d;
      c1_z_q     <= c1_z_d;
      c2_q       <= c2_d;
      c2_z_q     <= c2_z_d;
      c3_q       <= c3_d;
      strb_dly_q <= strb_dly_d;
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      i3_q       <= i3_d;
      d_out_q    <= d_out_d;
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb/tb_cic_interpolator.sv - self-checking bench for cic_interpolator
// Reference: impulse response = box-car(R) convolved three times, applied to strobed samples.
module tb_cic_interpolator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] interpolation_ratio = 16'd4;
  logic [7:0]  d_in = 8'h00;
  wire  [7:0]  d_out;
  wire         d_clk;

  int errors = 0;
  int checks = 0;
  int h[64];
  int hlen;

  always #5 clk = ~clk;

  cic_interpolator #(.width(18), .out_shift(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .interpolation_ratio (interpolation_ratio),
    .d_in                (d_in),
    .d_out               (d_out),
    .d_clk               (d_clk)
  );

  task automatic build_h(input int r);
    int cur[64];
    int nxt[64];
    int len;
    for (int i = 0; i < 64; i++) begin
      cur[i] = (i < r) ? 1 : 0;
      nxt[i] = 0;
    end
    len = r;
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 64; n++) begin
        nxt[n] = 0;
        for (int m = 0; m < r; m++)
          if (n - m >= 0 && n - m < len) nxt[n] += cur[n-m];
      end
      len = len + r - 1;
      cur = nxt;
    end
    for (int i = 0; i < 64; i++) h[i] = cur[i];
    hlen = len;
  endtask

  // Leaves the bench just after a falling edge with rst released: edge 1 is next.
  task automatic apply_reset(input int r);
    @(negedge clk);
    rst = 1'b0;
    d_in = 8'h00;
    interpolation_ratio = 16'(r);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic run_model(input int r, input int n, input int kind, input string name);
    int xs[$];
    int ks[$];
    int y;
    int x;
    int ramp;
    int idx;
    logic [7:0] exp_o;
    logic exp_clk;
    logic signed [7:0] sb;
    build_h(r);
    ramp = 0;
    for (int e = 0; e <= n; e++) begin
      y = 0;
      foreach (xs[j]) begin
        idx = e - 4 - ks[j];
        if (idx >= 0 && idx < hlen) y += xs[j] * h[idx];
      end
      exp_o = 8'(y >>> 4);
      checks++;
      if (d_out !== exp_o) begin
        errors++;
        $display("FAIL %s_dout R=%0d e=%0d got=%0d exp=%0d", name, r, e, $signed(d_out), $signed(exp_o));
      end
      exp_clk = ((e % r) == 0);
      checks++;
      if (d_clk !== exp_clk) begin
        errors++;
        $display("FAIL %s_dclk R=%0d e=%0d got=%b exp=%b", name, r, e, d_clk, exp_clk);
      end
      if (exp_clk) begin
        if (kind == 0) begin
          sb = 8'($urandom);
          x = int'(sb);
        end else begin
          x = 20 + 9 * ramp;
          ramp++;
        end
        d_in = 8'(x);
        xs.push_back(x);
        ks.push_back(e + 1);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    d_in = 8'h55;
    interpolation_ratio = 16'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (d_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_dout got=%h exp=00", d_out);
      end
      checks++;
      if (d_clk !== 1'b0) begin
        errors++;
        $display("FAIL reset_dclk got=%b exp=0", d_clk);
      end
    end
    rst = 1'b1;
    #1;
    for (int e = 0; e <= 12; e++) begin
      checks++;
      if (d_clk !== ((e % 4) == 0)) begin
        errors++;
        $display("FAIL reset_strobe e=%0d got=%b exp=%b", e, d_clk, (e % 4) == 0);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_impulse();
    int tbl[10];
    logic [7:0] exp_o;
    tbl = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    apply_reset(4);
    for (int e = 0; e <= 30; e++) begin
      exp_o = (e >= 5 && e <= 14) ? 8'(tbl[e-5]) : 8'h00;
      checks++;
      if (d_out !== exp_o) begin
        errors++;
        $display("FAIL impulse e=%0d got=%0d exp=%0d", e, $signed(d_out), $signed(exp_o));
      end
      d_in = (e == 0) ? 8'd16 : 8'd0;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_dc(input int val);
    apply_reset(4);
    d_in = 8'(val);
    for (int e = 0; e <= 40; e++) begin
      if (e >= 16) begin
        checks++;
        if (d_out !== 8'(val)) begin
          errors++;
          $display("FAIL dc e=%0d got=%0d exp=%0d", e, $signed(d_out), val);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_ratio_change();
    int nxt;
    int lat;
    logic exp_clk;
    apply_reset(4);
    nxt = 1;
    for (int e = 0; e <= 40; e++) begin
      if (e == 6) interpolation_ratio = 16'd8;
      if (e == 20) interpolation_ratio = 16'd0;
      exp_clk = (e + 1 == nxt);
      checks++;
      if (d_clk !== exp_clk) begin
        errors++;
        $display("FAIL ratio_change e=%0d got=%b exp=%b", e, d_clk, exp_clk);
      end
      if (exp_clk) begin
        lat = (int'(interpolation_ratio) > 1) ? int'(interpolation_ratio) : 1;
        nxt += lat;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    apply_reset(4);
    run_model(4, 24, 1, "ramp");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (d_out !== 8'h00) begin
      errors++;
      $display("FAIL async_dout got=%h exp=00", d_out);
    end
    checks++;
    if (d_clk !== 1'b0) begin
      errors++;
      $display("FAIL async_dclk got=%b exp=0", d_clk);
    end
    apply_reset(4);
    run_model(4, 40, 0, "restart");
  endtask

  task automatic test_random();
    int ratios[6];
    int r;
    ratios = '{1, 2, 3, 4, 5, 8};
    for (int k = 0; k < 6; k++) begin
      r = ratios[$urandom_range(0, 5)];
      apply_reset(r);
      run_model(r, 60, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc(10);
    test_dc(-128);
    test_ratio_change();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
